// File: rtl/mano_timing_ctrl.sv
// mano_timing_ctrl: timing-and-control sequencer for the scaled Mano basic
// computer (8-bit instructions, 4-bit addresses, 16-word memory).
// It holds the sequence counter SC, the run flip-flop S, the instruction
// indirect latch Ilat and, when built with MANO_INTR_EN defined, the
// interrupt-cycle flag R and the interrupt enable IEN.
// Every control strobe is a combinational decode of SC, Ilat, R and IR,
// gated by S, so a strobe is high for exactly the cycle of its T-step.
// SC and RUN expose the complete sequencer state.
// Optional feature macro: MANO_INTR_EN (interrupt cycle, ION/IOF).
module mano_timing_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] IR,
    input  logic       DR_ZERO,
    input  logic       SKIP,
    input  logic       INTR_REQ,
    output logic [3:0] SC,
    output logic       RUN,
    output logic       PC_INC,
    output logic       PC_LD,
    output logic       PC_CLR,
    output logic       AR_LD,
    output logic [1:0] AR_SEL,
    output logic       AR_INC,
    output logic       AR_CLR,
    output logic       IR_LD,
    output logic       DR_LD,
    output logic       DR_INC,
    output logic       AC_LD,
    output logic       MEM_RD,
    output logic       MEM_WR,
    output logic       REG_EXEC,
    output logic [1:0] WR_SEL,
    output logic [1:0] ALU_OP
);

    // T-step encoding of the sequence counter; values 7..15 are illegal.
    typedef enum logic [3:0] {
        T0 = 4'd0,
        T1 = 4'd1,
        T2 = 4'd2,
        T3 = 4'd3,
        T4 = 4'd4,
        T5 = 4'd5,
        T6 = 4'd6
    } tstep_e;

    logic [3:0] sc_q;
    logic       s_q;
    logic       ilat_q;
    logic       r_q;
    logic [2:0] opcode;
    logic       sc_clr;
    logic       hlt;

    assign opcode = IR[6:4];
    assign SC     = sc_q;
    assign RUN    = s_q;

    // Step decode: strobes for the current T-step plus the end-of-step action.
    always_comb begin
        PC_INC   = 1'b0;
        PC_LD    = 1'b0;
        PC_CLR   = 1'b0;
        AR_LD    = 1'b0;
        AR_SEL   = 2'b00;
        AR_INC   = 1'b0;
        AR_CLR   = 1'b0;
        IR_LD    = 1'b0;
        DR_LD    = 1'b0;
        DR_INC   = 1'b0;
        AC_LD    = 1'b0;
        MEM_RD   = 1'b0;
        MEM_WR   = 1'b0;
        REG_EXEC = 1'b0;
        WR_SEL   = 2'b00;
        ALU_OP   = 2'b00;
        sc_clr   = 1'b0;
        hlt      = 1'b0;
        if (s_q) begin
            if (r_q && (sc_q <= 4'd2)) begin
                // Interrupt cycle: save PC at address 0, vector to address 1.
                case (sc_q)
                    T0: AR_CLR = 1'b1;
                    T1: begin
                        MEM_WR = 1'b1;
                        WR_SEL = 2'b01;
                        PC_CLR = 1'b1;
                    end
                    default: begin
                        PC_INC = 1'b1;
                        sc_clr = 1'b1;
                    end
                endcase
            end else begin
                case (sc_q)
                    T0: AR_LD = 1'b1;
                    T1: begin
                        MEM_RD = 1'b1;
                        IR_LD  = 1'b1;
                        PC_INC = 1'b1;
                    end
                    T2: begin
                        AR_LD  = 1'b1;
                        AR_SEL = 2'b01;
                    end
                    T3: begin
                        if (opcode != 3'd7) begin
                            if (ilat_q) begin
                                MEM_RD = 1'b1;
                                AR_LD  = 1'b1;
                                AR_SEL = 2'b10;
                            end
                        end else begin
                            sc_clr = 1'b1;
                            if (!ilat_q) begin
                                if (IR[3:0] == 4'b0001) begin
                                    hlt = 1'b1;
                                end else begin
                                    REG_EXEC = 1'b1;
                                    PC_INC   = SKIP;
                                end
                            end
                        end
                    end
                    T4: begin
                        case (opcode)
                            3'd0, 3'd1, 3'd2, 3'd6: begin
                                MEM_RD = 1'b1;
                                DR_LD  = 1'b1;
                            end
                            3'd3: begin
                                MEM_WR = 1'b1;
                                sc_clr = 1'b1;
                            end
                            3'd4: begin
                                PC_LD  = 1'b1;
                                sc_clr = 1'b1;
                            end
                            3'd5: begin
                                MEM_WR = 1'b1;
                                WR_SEL = 2'b01;
                                AR_INC = 1'b1;
                            end
                            default: sc_clr = 1'b1;
                        endcase
                    end
                    T5: begin
                        case (opcode)
                            3'd0, 3'd1, 3'd2: begin
                                AC_LD  = 1'b1;
                                ALU_OP = IR[5:4];
                                sc_clr = 1'b1;
                            end
                            3'd5: begin
                                PC_LD  = 1'b1;
                                sc_clr = 1'b1;
                            end
                            3'd6: DR_INC = 1'b1;
                            default: sc_clr = 1'b1;
                        endcase
                    end
                    T6: begin
                        if (opcode == 3'd6) begin
                            MEM_WR = 1'b1;
                            WR_SEL = 2'b10;
                            PC_INC = DR_ZERO;
                        end
                        sc_clr = 1'b1;
                    end
                    // SC outside 0..6 is never reached normally; recover to T0.
                    default: sc_clr = 1'b1;
                endcase
            end
        end
    end

    // Sequencer state: SC, run flip-flop and the indirect-bit latch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sc_q   <= 4'd0;
            s_q    <= 1'b0;
            ilat_q <= 1'b0;
        end else if (!s_q) begin
            // Halted: SC parked at 0; START begins a fresh fetch at T0.
            sc_q <= 4'd0;
            if (START) begin
                s_q <= 1'b1;
            end
        end else begin
            if (sc_clr) begin
                sc_q <= 4'd0;
            end else begin
                sc_q <= sc_q + 4'd1;
            end
            if (hlt) begin
                s_q <= 1'b0;
            end
            if (!r_q && (sc_q == 4'd2)) begin
                ilat_q <= IR[7];
            end
        end
    end

`ifdef MANO_INTR_EN
    logic ien_q;
    logic io_step;
    logic ion;
    logic iof;

    // An I/O instruction is opcode 7 with I = 1, executed in T3 of a normal cycle.
    assign io_step = s_q && !r_q && (sc_q == 4'd3) && (opcode == 3'd7) && ilat_q;
    assign ion     = io_step && (IR[3:0] == 4'b1000);
    assign iof     = io_step && (IR[3:0] == 4'b0100);

    // Interrupt state: IEN set/cleared by ION/IOF, R raised outside fetch T0..T2.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q   <= 1'b0;
            ien_q <= 1'b0;
        end else if (s_q && r_q && (sc_q == 4'd2)) begin
            r_q   <= 1'b0;
            ien_q <= 1'b0;
        end else begin
            if (ion) begin
                ien_q <= 1'b1;
            end else if (iof) begin
                ien_q <= 1'b0;
            end
            if (s_q && ien_q && INTR_REQ && !r_q && (sc_q > 4'd2)) begin
                r_q <= 1'b1;
            end
        end
    end
`else
    logic unused_intr_req;

    // Interrupts not built: R is tied off and the request line is ignored.
    assign r_q             = 1'b0;
    assign unused_intr_req = INTR_REQ;
`endif

endmodule

// File: doc/mano_timing_ctrl.md
# mano_timing_ctrl

Timing-and-control sequencer for the scaled Mano basic computer: 8-bit instructions, 4-bit addresses, 16-word memory. It owns the sequence counter (SC) and the run flip-flop (S), and decodes SC together with the instruction register into per-cycle strobes for the program counter, AR, IR, DR, AC and memory. It sits beside the datapath registers and is their only source of control strobes.

## Interface
Parameters: none; widths are fixed by the 4-bit program counter.
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  sets S when halted
- IR  in  8  instruction register contents: IR[7] = I, IR[6:4] = opcode, IR[3:0] = address / register-op field
- DR_ZERO  in  1  DR == 0, sampled in ISZ T6
- SKIP  in  1  register-op skip condition, sampled in T3
- INTR_REQ  in  1  interrupt request (see Configuration)
- SC  out  4  sequence counter
- RUN  out  1  S flip-flop
- PC_INC / PC_LD / PC_CLR  out  1 each  PC strobes; PC_LD loads from AR
- AR_LD  out  1  AR load strobe
- AR_SEL  out  2  AR source: 00 = PC, 01 = IR[3:0], 10 = memory data
- AR_INC / AR_CLR  out  1 each  AR strobes
- IR_LD / DR_LD / DR_INC / AC_LD / MEM_RD / MEM_WR / REG_EXEC  out  1 each  strobes
- WR_SEL  out  2  memory write source: 00 = AC, 01 = PC, 10 = DR
- ALU_OP  out  2  AC operation: 00 = AND, 01 = ADD, 10 = LOAD

## Operation
- Only SC, S, R (interrupt cycle), IEN and Ilat are registers. All strobes are combinational decodes of SC, Ilat, R and IR, gated by S.
- All strobes are 0 when S = 0. Unlisted outputs are 0 in every step.
- Each step ends in one of two ways: SC increments, or "SC clr" (SC returns to 0).
- Fetch:
  - T0: AR_LD, AR_SEL=00.
  - T1: MEM_RD, IR_LD, PC_INC.
  - T2: AR_LD, AR_SEL=01; Ilat ← IR[7].
- T3:
  - opcode ≠ 7 and Ilat = 1: MEM_RD, AR_LD, AR_SEL=10.
  - opcode ≠ 7 and Ilat = 0: no strobes.
  - opcode = 7 and Ilat = 0:
    - IR[3:0] = 0001: HLT, S cleared.
    - otherwise: REG_EXEC, plus PC_INC if SKIP.
    - SC clr in both cases.
  - opcode = 7 and Ilat = 1: I/O instruction; SC clr.
- Memory reference, from T4:
  - AND/ADD/LDA (opcodes 0/1/2):
    - T4: MEM_RD, DR_LD.
    - T5: AC_LD, ALU_OP = opcode[1:0]; SC clr.
  - STA (3): T4: MEM_WR, WR_SEL=00; SC clr.
  - BUN (4): T4: PC_LD; SC clr.
  - BSA (5):
    - T4: MEM_WR, WR_SEL=01, AR_INC.
    - T5: PC_LD; SC clr.
  - ISZ (6):
    - T4: MEM_RD, DR_LD.
    - T5: DR_INC.
    - T6: MEM_WR, WR_SEL=10, plus PC_INC if DR_ZERO; SC clr.
- START with S = 0: S ← 1 and SC ← 0. START with S = 1 is ignored.
- SC never exceeds 6. If SC reaches 7–15, the block forces SC clr (defensive).

## Timing
- Reset: SC = 0, S = 0, R = 0, IEN = 0, Ilat = 0; all outputs 0.
- RST has priority over START, HLT and the interrupt.
- RST mid-instruction aborts the instruction immediately; there is no completion.
- Each strobe is asserted for exactly the one cycle of its T-step. The datapath acts on it at the closing rising edge.
- IR is valid from T2; the IR load happens at the T1→T2 edge.
- Instruction latency in cycles, START edge to first T0 = 1:
  - register op / I/O: 4
  - STA, BUN: 5
  - AND, ADD, LDA, BSA: 6
  - ISZ: 7
  - add 0 for indirect; T3 is always consumed.
- HLT: S = 0 after the T3 edge; SC = 0; no further strobes.
- PC_INC together with PC_LD or PC_CLR never occurs.

## Configuration
- Macro `MANO_INTR_EN`.
- When defined:
  - I/O instruction IR[3:0] = 1000 (ION) sets IEN; IR[3:0] = 0100 (IOF) clears IEN.
  - R is set at an edge when S & IEN & INTR_REQ & !R and SC ∉ {0, 1, 2}.
  - When R = 1, the interrupt cycle replaces fetch:
    - RT0: AR_CLR.
    - RT1: MEM_WR, WR_SEL=01, PC_CLR.
    - RT2: PC_INC; IEN ← 0, R ← 0; SC clr.
- When undefined: INTR_REQ is ignored, R and IEN stay 0, and ION/IOF act as plain I/O no-ops.

## Test plan
- Reset and start: RST held 2 cycles → every output 0, SC = 0, RUN = 0. Then START for 1 cycle → RUN = 1, T0 shows AR_LD with AR_SEL=00.
- Direct LDA, IR = 8'h25 → T0..T5 strobes exactly as listed, with ALU_OP=10 at T5; SC returns to 0 after 6 cycles.
- Indirect BUN, IR = 8'hC3 → T3 shows MEM_RD with AR_SEL=10; T4 shows PC_LD; SC clr.
- ISZ, IR = 8'h60:
  - DR_ZERO = 1 → PC_INC at T6, together with MEM_WR and WR_SEL=10.
  - repeat with DR_ZERO = 0 → no PC_INC.
- HLT (IR = 8'h71), then START pulses mid-sequence: RUN = 0 after T3 and all strobes stay 0. A START asserted while RUN = 1 has no effect.
- With MANO_INTR_EN:
  - ION (IR = 8'hF8), then INTR_REQ during a later T4 → next cycles are RT0 AR_CLR; RT1 MEM_WR WR_SEL=01 PC_CLR; RT2 PC_INC; IEN = 0 afterwards.
  - RST asserted during RT1 → all registers are 0 on the next cycle.
